// File: rtl/serial_slot_scheduler_pkg.sv
// serial_slot_scheduler_pkg: shared encodings and constants for the slot scheduler
package serial_slot_scheduler_pkg;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HUNT = 2'd1;
  localparam logic [1:0] ST_PAYLOAD = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;
  localparam logic [1:0] H0 = 2'd0;
  localparam logic [1:0] H1 = 2'd1;
  localparam logic [1:0] H2 = 2'd2;
  localparam logic [2:0] PREAMBLE = 3'b010;
  localparam int SESS_W = 10;
endpackage

// File: rtl/serial_slot_scheduler_rr_arbiter.sv
// serial_slot_scheduler_rr_arbiter: combinational round-robin pick starting after last_i
module serial_slot_scheduler_rr_arbiter #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic [IW-1:0] owner_o,
  output logic          any_o
);
  logic [IW-1:0] idx;
  // Scan farthest-first so the nearest requester after last_i wins.
  always_comb begin
    owner_o = last_i;
    idx = '0;
    for (int k = N; k >= 1; k--) begin
      idx = IW'((32'(last_i) + 32'(k)) % N);
      if (req_i[idx]) owner_o = idx;
    end
    any_o = |req_i;
  end
endmodule

// File: rtl/serial_slot_scheduler.sv
// serial_slot_scheduler: round-robin shared "010" preamble hunter and payload capture for N serial requesters
module serial_slot_scheduler
  import serial_slot_scheduler_pkg::*;
#(
  parameter int N = 4,
  parameter int TIMEOUT = 64,
  parameter int PAYLOAD_W = 8,
  localparam int IW = $clog2(N)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N-1:0]          req,
  input  logic [N-1:0]          bit_in,
  output logic [N-1:0]          gnt,
  output logic                  busy,
  output logic [PAYLOAD_W-1:0]  payload,
  output logic                  payload_valid,
  output logic [IW-1:0]         payload_src,
  output logic                  timeout_pulse,
  output logic [SESS_W-1:0]     session_count
);
  localparam int HW = $clog2(TIMEOUT);
  localparam int BW = $clog2(PAYLOAD_W);
  logic [1:0] state_q, state_d, hunt_q, hunt_d, hunt_nx;
  logic [IW-1:0] owner_q, owner_d, last_q, last_d, src_q, src_d, arb_owner;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic [PAYLOAD_W-2:0] shreg_q, shreg_d;
  logic [PAYLOAD_W-1:0] payload_q, payload_d, shifted;
  logic [SESS_W-1:0] sess_q, sess_d;
  logic tout_q, tout_d, any_req, b, match;

  serial_slot_scheduler_rr_arbiter #(.N(N)) u_rr_arbiter (
    .req_i(req),
    .last_i(last_q),
    .owner_o(arb_owner),
    .any_o(any_req)
  );

  // Overlapping detector: a 0 always leaves a usable "0" prefix, a 1 only helps after "0".
  always_comb begin
    b = bit_in[owner_q];
    match = hunt_q == H2 && b == PREAMBLE[0];
    hunt_nx = b == PREAMBLE[2] ? H1 : (hunt_q == H1 ? H2 : H0);
    shifted = {shreg_q, b};
    state_d = state_q;
    hunt_d = hunt_q;
    owner_d = owner_q;
    last_d = last_q;
    hcnt_d = hcnt_q;
    bcnt_d = bcnt_q;
    shreg_d = shreg_q;
    payload_d = payload_q;
    src_d = src_q;
    sess_d = sess_q;
    tout_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          owner_d = arb_owner;
          state_d = ST_HUNT;
          hunt_d = H0;
          hcnt_d = '0;
        end
      end
      ST_HUNT: begin
        if (!req[owner_q]) begin
          state_d = ST_IDLE;
          last_d = owner_q;
        end else if (match) begin
          state_d = ST_PAYLOAD;
          bcnt_d = '0;
        end else if (hcnt_q == HW'(TIMEOUT - 1)) begin
          state_d = ST_IDLE;
          last_d = owner_q;
          tout_d = 1'b1;
        end else begin
          hunt_d = hunt_nx;
          hcnt_d = hcnt_q + 1'b1;
        end
      end
      ST_PAYLOAD: begin
        shreg_d = shifted[PAYLOAD_W-2:0];
        bcnt_d = bcnt_q + 1'b1;
        if (bcnt_q == BW'(PAYLOAD_W - 1)) begin
          state_d = ST_DONE;
          payload_d = shifted;
          src_d = owner_q;
          sess_d = sess_q + 1'b1;
        end
      end
      default: begin
        last_d = owner_q;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      hunt_q <= H0;
      owner_q <= '0;
      last_q <= IW'(N - 1);
      hcnt_q <= '0;
      bcnt_q <= '0;
      shreg_q <= '0;
      payload_q <= '0;
      src_q <= '0;
      tout_q <= 1'b0;
      sess_q <= '0;
    end else begin
      state_q <= state_d;
      hunt_q <= hunt_d;
      owner_q <= owner_d;
      last_q <= last_d;
      hcnt_q <= hcnt_d;
      bcnt_q <= bcnt_d;
      shreg_q <= shreg_d;
      payload_q <= payload_d;
      src_q <= src_d;
      tout_q <= tout_d;
      sess_q <= sess_d;
    end
  end

  assign gnt = (state_q == ST_HUNT || state_q == ST_PAYLOAD) ? N'(1) << owner_q : '0;
  assign busy = state_q != ST_IDLE;
  assign payload = payload_q;
  assign payload_valid = state_q == ST_DONE;
  assign payload_src = src_q;
  assign timeout_pulse = tout_q;
  assign session_count = sess_q;
endmodule

// File: tb/tb_serial_slot_scheduler.sv
// tb_serial_slot_scheduler: randomized scoreboard bench for serial_slot_scheduler
module tb_serial_slot_scheduler;
  localparam int N = 4;
  localparam int TO = 64;
  localparam int PW = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] req = '0;
  logic [N-1:0] bit_in = '0;
  logic [N-1:0] gnt;
  logic busy, payload_valid, timeout_pulse;
  logic [PW-1:0] payload;
  logic [1:0] payload_src;
  logic [9:0] session_count;
  typedef struct {
    int cyc;
    int a;
    int b;
    int s;
  } ev_t;
  ev_t gq[$];
  ev_t pq[$];
  ev_t tq[$];
  int src_log[$];
  int sq[N][$];
  int hist[$];
  int cyc = 0, n_cmp = 0, n_err = 0, n_pay = 0, n_to = 0;
  int last_gnt_cyc = 0, last_pay_cyc = 0, prefix_max = 0;
  int m_phase = 0, m_owner = 0, m_last = N - 1, m_word = 0, m_nb = 0, m_sess = 0;
  bit autofill = 1'b0;
  bit wrap_seen = 1'b0;

  always #5 clk = ~clk;

  serial_slot_scheduler #(.N(N), .TIMEOUT(TO), .PAYLOAD_W(PW)) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .bit_in(bit_in),
    .gnt(gnt),
    .busy(busy),
    .payload(payload),
    .payload_valid(payload_valid),
    .payload_src(payload_src),
    .timeout_pulse(timeout_pulse),
    .session_count(session_count)
  );

  function automatic ev_t mk(int c, int a, int b, int s);
    ev_t e;
    e.cyc = c;
    e.a = a;
    e.b = b;
    e.s = s;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  function automatic int rr_pick(int last, logic [N-1:0] r);
    for (int k = 1; k <= N; k++) if (r[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  // Reference: sessions described by the owner's sampled bit history.
  task automatic model_step();
    int n;
    if (rst) begin
      m_phase = 0;
      m_last = N - 1;
      m_sess = 0;
      hist.delete();
      return;
    end
    case (m_phase)
      0: if (req != '0) begin
        m_owner = rr_pick(m_last, req);
        gq.push_back(mk(cyc, m_owner, 0, 0));
        hist.delete();
        m_phase = 1;
      end
      1: if (!req[m_owner]) begin
        m_phase = 0;
        m_last = m_owner;
      end else begin
        hist.push_back(int'(bit_in[m_owner]));
        n = hist.size();
        if (n >= 3 && hist[n-3] == 0 && hist[n-2] == 1 && hist[n-1] == 0) begin
          m_phase = 2;
          m_word = 0;
          m_nb = 0;
        end else if (n == TO) begin
          m_phase = 0;
          m_last = m_owner;
          tq.push_back(mk(cyc, 0, 0, 0));
        end
      end
      2: begin
        m_word = m_word * 2 + int'(bit_in[m_owner]);
        m_nb++;
        if (m_nb == PW) begin
          m_phase = 3;
          m_sess = (m_sess + 1) % 1024;
          pq.push_back(mk(cyc, m_word, m_owner, m_sess));
        end
      end
      default: begin
        m_last = m_owner;
        m_phase = 0;
      end
    endcase
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
    model_step();
  end

  task automatic push_bits(int r, int v, int nb);
    for (int i = nb - 1; i >= 0; i--) sq[r].push_back((v >> i) & 1);
  endtask

  task automatic push_session(int r, int v);
    push_bits(r, 2, 3);
    push_bits(r, v, PW);
  endtask

  // Line driver: the owner's stream advances only while it is granted.
  initial forever begin
    @(posedge clk);
    #1;
    for (int r = 0; r < N; r++) begin
      if (gnt[r] && autofill && sq[r].size() == 0) begin
        push_bits(r, int'($urandom), int'($urandom_range(0, prefix_max)));
        push_session(r, int'($urandom_range(0, 255)));
      end
      if (gnt[r] && sq[r].size() > 0) bit_in[r] = 1'(sq[r].pop_front());
      else bit_in[r] = 1'($urandom);
    end
  end

  initial begin
    logic [N-1:0] pg;
    int gi;
    ev_t e;
    pg = '0;
    forever begin
      @(negedge clk);
      if (gnt != '0 && pg == '0) begin
        gi = -1;
        for (int i = 0; i < N; i++) if (gnt[i]) gi = i;
        last_gnt_cyc = cyc;
        chk("gnt_onehot", $countones(gnt), 1);
        chk("gnt_expected", 32'(gq.size() > 0), 1);
        if (gq.size() > 0) begin
          e = gq.pop_front();
          chk("gnt_owner", gi, e.a);
          chk("gnt_cycle", cyc, e.cyc);
        end
      end
      if (payload_valid) begin
        n_pay++;
        last_pay_cyc = cyc;
        src_log.push_back(int'(payload_src));
        if (session_count == 10'd0) wrap_seen = 1'b1;
        chk("pay_expected", 32'(pq.size() > 0), 1);
        if (pq.size() > 0) begin
          e = pq.pop_front();
          chk("payload", payload, e.a);
          chk("payload_src", payload_src, e.b);
          chk("session_count", session_count, e.s);
          chk("pay_cycle", cyc, e.cyc);
        end
        chk("done_gnt", gnt, 0);
        chk("done_busy", busy, 1);
      end
      if (timeout_pulse) begin
        n_to++;
        chk("to_expected", 32'(tq.size() > 0), 1);
        if (tq.size() > 0) begin
          e = tq.pop_front();
          chk("to_cycle", cyc, e.cyc);
        end
        chk("to_gnt", gnt, 0);
      end
      if (gq.size() > 0) begin
        chk("gnt_missing", 32'(gq[0].cyc > cyc), 1);
        if (gq[0].cyc <= cyc) e = gq.pop_front();
      end
      if (pq.size() > 0) begin
        chk("pay_missing", 32'(pq[0].cyc > cyc), 1);
        if (pq[0].cyc <= cyc) e = pq.pop_front();
      end
      if (tq.size() > 0) begin
        chk("to_missing", 32'(tq[0].cyc > cyc), 1);
        if (tq[0].cyc <= cyc) e = tq.pop_front();
      end
      pg = gnt;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_pay(int target, int budget);
    int t = 0;
    while (n_pay < target && t < budget) begin
      tick(1);
      t++;
    end
    chk("wait_payload", 32'(n_pay >= target), 1);
  endtask

  task automatic chk_reset(string tag);
    chk({tag, "_gnt"}, gnt, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_payload"}, payload, 0);
    chk({tag, "_valid"}, payload_valid, 0);
    chk({tag, "_src"}, payload_src, 0);
    chk({tag, "_timeout"}, timeout_pulse, 0);
    chk({tag, "_sess"}, session_count, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    tick(2);
    rst = 1'b0;
    for (int r = 0; r < N; r++) sq[r].delete();
    tick(1);
  endtask

  initial begin
    int base, to0;
    int exp_src[5];
    exp_src = '{0, 1, 2, 3, 0};
    tick(3);
    @(negedge clk);
    chk_reset("rst");
    rst = 1'b0;
    push_bits(0, 4'b1010, 4);
    push_bits(0, 8'hA5, 8);
    req = 4'b0001;
    @(posedge clk);
    @(negedge clk);
    chk("t1_gnt_latency", gnt, 4'b0001);
    wait_pay(1, 40);
    req = '0;
    chk("t1_payload", payload, 8'hA5);
    chk("t1_src", payload_src, 0);
    chk("t1_sess", session_count, 1);
    tick(3);
    do_reset();
    base = n_pay;
    src_log.delete();
    for (int r = 0; r < N; r++) push_session(r, 8'h3C);
    push_session(0, 8'h3C);
    req = '1;
    wait_pay(base + 5, 200);
    req = '0;
    tick(3);
    chk("t2_count", src_log.size(), 5);
    for (int i = 0; i < 5 && i < src_log.size(); i++) chk("t2_order", src_log[i], exp_src[i]);
    chk("t2_payload", payload, 8'h3C);
    base = n_pay;
    push_bits(1, 7'b0011010, 7);
    push_bits(1, 8'h96, 8);
    req = 4'b0010;
    wait_pay(base + 1, 60);
    req = '0;
    chk("t3_payload", payload, 8'h96);
    chk("t3_src", payload_src, 1);
    chk("t3_match_latency", last_pay_cyc - last_gnt_cyc, 15);
    tick(3);
    do_reset();
    base = n_pay;
    to0 = n_to;
    repeat (70) sq[0].push_back(1);
    push_session(1, 8'h5A);
    req = 4'b0011;
    wait_pay(base + 1, 200);
    req = '0;
    tick(2);
    sq[0].delete();
    chk("t4_timeouts", n_to - to0, 1);
    chk("t4_src", payload_src, 1);
    chk("t4_payload", payload, 8'h5A);
    chk("t4_sess", session_count, 1);
    base = n_pay;
    to0 = n_to;
    push_bits(2, 4'b1111, 4);
    req = 4'b0100;
    tick(3);
    req = '0;
    tick(4);
    sq[2].delete();
    chk("t5a_busy", busy, 0);
    chk("t5a_no_pay", n_pay, base);
    chk("t5a_no_to", n_to, to0);
    push_session(3, 8'hC3);
    req = 4'b1000;
    tick(6);
    req = '0;
    wait_pay(base + 1, 40);
    chk("t5b_payload", payload, 8'hC3);
    chk("t5b_src", payload_src, 3);
    tick(3);
    push_session(0, 8'hFF);
    req = 4'b0001;
    tick(6);
    chk("t5c_in_session", busy, 1);
    rst = 1'b1;
    req = '0;
    @(posedge clk);
    @(negedge clk);
    chk_reset("t5c");
    rst = 1'b0;
    sq[0].delete();
    tick(3);
    chk("t5c_no_pay", n_pay, base + 1);
    autofill = 1'b1;
    prefix_max = 6;
    repeat (1500) begin
      if ($urandom_range(0, 7) == 0) req = N'($urandom);
      tick(1);
    end
    req = '0;
    tick(20);
    autofill = 1'b0;
    do_reset();
    base = n_pay;
    wrap_seen = 1'b0;
    autofill = 1'b1;
    prefix_max = 0;
    req = '1;
    wait_pay(base + 1025, 16000);
    req = '0;
    tick(5);
    autofill = 1'b0;
    chk("t7_wrap_seen", 32'(wrap_seen), 1);
    chk("t7_sess", session_count, 1);
    tick(5);
    chk("pending_gnt", gq.size(), 0);
    chk("pending_pay", pq.size(), 0);
    chk("pending_to", tq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/serial_slot_scheduler.md
Name: serial_slot_scheduler

Overview:
- Shares one "010"-preamble detector and payload capture engine among N serial requesters.
- Round-robin arbiter grants one requester at a time. While granted, the owner's bit stream is hunted for the preamble 0,1,0, then the next 8 bits are captured as a payload word.
- Each completed session increments a 10-bit session counter. Sits between the line-interface slots and the user-accounting logic.

Parameters:
- N, 4, number of requesters (2..8)
- TIMEOUT, 64, max HUNT cycles without a preamble before the grant is revoked
- PAYLOAD_W, 8, payload bits captured after the preamble

Ports:
- clk  input  1  single clock, all logic on posedge
- rst  input  1  synchronous, active-high reset
- req  input  N  per-requester request, level
- bit_in  input  N  per-requester serial data, sampled only for the current owner
- gnt  output  N  one-hot grant; all-zero when not granted
- busy  output  1  high in HUNT, PAYLOAD, DONE
- payload  output  PAYLOAD_W  captured word, MSB first on the line
- payload_valid  output  1  one-cycle pulse, payload and payload_src valid
- payload_src  output  clog2(N)  index of the requester that produced the payload
- timeout_pulse  output  1  one-cycle pulse when a HUNT times out
- session_count  output  10  completed sessions; wraps 1023 -> 0

Behaviour:
- Reset:
  - Synchronous on rst=1 at posedge. Top state is IDLE and the hunt sub-state is H0.
  - gnt=0, busy=0, payload=0, payload_valid=0, payload_src=0, timeout_pulse=0, session_count=0.
  - last_owner=N-1, so requester 0 has first priority after reset.
- rst overrides everything, including mid-PAYLOAD. No pulse is emitted on a reset abort.
- Top states: IDLE, HUNT, PAYLOAD, DONE. All outputs are registered or decoded from registered state only.
- IDLE:
  - If req != 0, the new owner is the first requester with req=1 searching last_owner+1, +2, ... modulo N. Owner is registered and the state goes to HUNT.
  - Latency: req seen at cycle k gives gnt[owner]=1 from cycle k+1.
- gnt[owner]=1 only in HUNT and PAYLOAD.
- HUNT: 3-state overlapping detector on bit_in[owner], one bit sampled per cycle.
  - H0: 0 -> H1; 1 -> H0.
  - H1: 0 -> H1; 1 -> H2.
  - H2: 0 -> PAYLOAD (bit counter cleared); 1 -> H0.
  - Hunt cycle counter counts HUNT cycles from 1. If the TIMEOUT-th HUNT cycle does not complete the preamble, the next state is IDLE and timeout_pulse=1 in that IDLE cycle.
  - A match on the TIMEOUT-th cycle wins over the timeout.
  - If req[owner]=0 during HUNT: abort to IDLE next cycle, no pulse, last_owner updated.
- PAYLOAD:
  - Shifts exactly PAYLOAD_W bits of bit_in[owner], MSB first, into a shift register; bit counter runs 0..PAYLOAD_W-1.
  - req[owner] is ignored (the session completes). Preamble detection is off.
  - After the last bit: state DONE, payload loaded, payload_src=owner, session_count incremented at the same edge.
- DONE: one cycle. payload_valid=1, gnt=0, busy=1. last_owner=owner, next state IDLE.
- Timing: final preamble 0 sampled at cycle m; payload bits at m+1..m+8; DONE at m+9; IDLE at m+10; next grant earliest m+11.
- payload and payload_src hold their values until the next DONE.
- Simultaneous requests are resolved by the round-robin rule only. A requester raising req while another owns the slot waits; there is no preemption.
- session_count wraps modulo 1024 and does not saturate.

Decomposition:
- Shared package holds:
  - the top-state encoding (IDLE, HUNT, PAYLOAD, DONE);
  - the hunt sub-state encoding (H0, H1, H2);
  - the preamble constant 3'b010;
  - the session counter width 10.
- One sub-module, rr_arbiter: N-bit req and last_owner in, owner index and any_req out, purely combinational.

Test Plan:
- Reset, then req=4'b0001, bit_in[0] stream 1,0,1,0 then 1010_0101 -> gnt=0001 one cycle after req; payload_valid pulse with payload=8'hA5, payload_src=0; session_count=1; gnt=0 in DONE.
- req=4'b1111 held, every stream sends preamble plus 8'h3C -> owners granted in order 0,1,2,3,0; each DONE gives payload=8'h3C with the matching payload_src.
- Overlap: bit_in[0] sequence 0,0,1,1,0,1,0 then payload -> match only on the final 0, at the 7th sampled bit.
- req=0001 with bit_in[0] held at 1 -> after 64 HUNT cycles, timeout_pulse=1 for one cycle, gnt=0, session_count unchanged; the next grant goes to the next requester.
- Drop req[owner] in HUNT -> IDLE, no pulses. Drop req[owner] mid-PAYLOAD -> payload still completes. Assert rst mid-PAYLOAD -> all outputs at reset values the next cycle, no payload_valid.
- Run 1024 sessions -> session_count wraps from 1023 to 0 on the 1024th payload_valid.
